// File: rtl/decoder_pkg.sv
// Shared definitions for the scanning N-bit decoder: controller state
// encoding and the width of the per-index hold counter.
package decoder_pkg;

    // Controller state: DIRECT follows the sel handshake, SCAN walks the index
    typedef enum logic {
        DIRECT = 1'b0,
        SCAN   = 1'b1
    } state_t;

    // Hold counter width; HOLD (and HOLD+1 with blanking) must fit in it
    localparam int HOLD_W = 8;

endpackage

// File: rtl/decoder_onehot.sv
// Combinational N -> 2**N one-hot expander with an enable; all-zero when
// the enable is low.
module decoder_onehot #(
    parameter int N = 3
) (
    input  logic              en,
    input  logic [N-1:0]      idx,
    output logic [2**N-1:0]   y
);

    // Set exactly one bit at the selected position, or none when disabled
    always_comb begin
        y = '0;
        if (en) begin
            y[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/decoder_nbit_scan.sv
// N-bit decoder with a DIRECT mode (sel handshake) and a SCAN mode that
// walks the one-hot output across all 2**N positions, HOLD cycles each.
// Optional build macro DECODER_BLANK_EN inserts one blank (all-zero)
// cycle after every hold period while scanning.
module decoder_nbit_scan
    import decoder_pkg::*;
#(
    parameter int N    = 3,
    parameter int HOLD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              e,
    input  logic              mode,
    input  logic              sel_valid,
    output logic              sel_ready,
    input  logic [N-1:0]      sel,
    output logic [2**N-1:0]   y,
    output logic              wrap
);

    localparam int W = 2**N;
    localparam logic [N-1:0] IDX_LAST = {N{1'b1}};

    // The hold counter runs 0..STEP_LAST on each index; with blanking the
    // final count is the blank cycle, giving HOLD+1 cycles per step.
`ifdef DECODER_BLANK_EN
    localparam logic [HOLD_W-1:0] STEP_LAST = HOLD_W'(HOLD);
    localparam bit                BLANK     = 1'b1;
`else
    localparam logic [HOLD_W-1:0] STEP_LAST = HOLD_W'(HOLD - 1);
    localparam bit                BLANK     = 1'b0;
`endif

    state_t              state_q;
    state_t              state_n;
    logic [N-1:0]        idx_q;
    logic [N-1:0]        idx_n;
    logic [HOLD_W-1:0]   hold_q;
    logic [HOLD_W-1:0]   hold_n;
    logic                active_q;
    logic                active_n;
    logic                wrap_q;
    logic                wrap_n;
    logic [W-1:0]        y_q;
    logic [W-1:0]        y_n;
    logic                accept;
    logic                blank_n;
    logic                show_n;

    // Next-state, counters and handshake; the state tracks mode one cycle late,
    // and entering SCAN restarts the walk at index 0 ahead of any sel accept
    always_comb begin
        state_n   = mode ? SCAN : DIRECT;
        idx_n     = idx_q;
        hold_n    = hold_q;
        active_n  = active_q;
        wrap_n    = 1'b0;
        sel_ready = (state_q == DIRECT);
        accept    = sel_valid && sel_ready;

        case (state_q)
            DIRECT: begin
                if (mode) begin
                    idx_n    = '0;
                    hold_n   = '0;
                    active_n = 1'b1;
                end else if (accept) begin
                    idx_n    = sel;
                    active_n = 1'b1;
                end
            end
            SCAN: begin
                if (e) begin
                    if (hold_q == STEP_LAST) begin
                        hold_n = '0;
                        idx_n  = idx_q + 1'b1;
                        wrap_n = (idx_q == IDX_LAST);
                    end else begin
                        hold_n = hold_q + 1'b1;
                    end
                end
            end
            default: begin
                state_n = DIRECT;
            end
        endcase

        blank_n = BLANK && (state_n == SCAN) && (hold_n == STEP_LAST);
        show_n  = e && active_n && !blank_n;
    end

    decoder_onehot #(
        .N (N)
    ) u_onehot (
        .en  (show_n),
        .idx (idx_n),
        .y   (y_n)
    );

    // State, counters and registered outputs; reset overrides everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= DIRECT;
            idx_q    <= '0;
            hold_q   <= '0;
            active_q <= 1'b0;
            wrap_q   <= 1'b0;
            y_q      <= '0;
        end else begin
            state_q  <= state_n;
            idx_q    <= idx_n;
            hold_q   <= hold_n;
            active_q <= active_n;
            wrap_q   <= wrap_n;
            y_q      <= y_n;
        end
    end

    assign y    = y_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_decoder_nbit_scan.sv
// Scoreboard bench for decoder_nbit_scan (default build, N=3, HOLD=4).
// The driver pushes the expected post-edge outputs from a cycle-count
// model; a monitor pops and compares after every rising edge.
module tb_decoder_nbit_scan;

    localparam int N    = 3;
    localparam int HOLD = 4;
    localparam int W    = 1 << N;

    typedef struct {
        logic [W-1:0] y;
        logic         wrap;
        logic         ready;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           e = 1'b1;
    logic           mode = 1'b0;
    logic           sel_valid = 1'b0;
    logic           sel_ready;
    logic [N-1:0]   sel = '0;
    logic [W-1:0]   y;
    logic           wrap;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Model: SCAN position derived from enabled steps since entry
    bit m_scan  = 1'b0;
    int m_t     = 0;
    int m_idx   = 0;
    bit m_shown = 1'b0;

    decoder_nbit_scan #(
        .N    (N),
        .HOLD (HOLD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .e         (e),
        .mode      (mode),
        .sel_valid (sel_valid),
        .sel_ready (sel_ready),
        .sel       (sel),
        .y         (y),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input bit r, input bit m, input bit en,
                                 input bit v, input logic [N-1:0] s);
        exp_t x;
        @(negedge clk);
        rst       = r;
        mode      = m;
        e         = en;
        sel_valid = v;
        sel       = s;
        x.y    = '0;
        x.wrap = 1'b0;
        if (r) begin
            m_scan  = 1'b0;
            m_t     = 0;
            m_idx   = 0;
            m_shown = 1'b0;
        end else begin
            if (!m_scan) begin
                if (m) begin
                    m_t     = 0;
                    m_idx   = 0;
                    m_shown = 1'b1;
                end else if (v) begin
                    m_idx   = int'(s);
                    m_shown = 1'b1;
                end
            end else if (en) begin
                m_t    = m_t + 1;
                m_idx  = (m_t / HOLD) % W;
                x.wrap = ((m_t % (HOLD * W)) == 0);
            end
            m_scan = m;
            if (en && m_shown) begin
                x.y[m_idx] = 1'b1;
            end
        end
        x.ready = !m_scan;
        sb.push_back(x);
    endtask

    task automatic checkOutput(input exp_t x);
        n_cmp = n_cmp + 3;
        if (y !== x.y) begin
            n_bad = n_bad + 1;
            $display("[TB] FAIL y at %0t: got %h expected %h", $time, y, x.y);
        end
        if (wrap !== x.wrap) begin
            n_bad = n_bad + 1;
            $display("[TB] FAIL wrap at %0t: got %b expected %b", $time, wrap, x.wrap);
        end
        if (sel_ready !== x.ready) begin
            n_bad = n_bad + 1;
            $display("[TB] FAIL sel_ready at %0t: got %b expected %b", $time, sel_ready, x.ready);
        end
    endtask

    // Monitor: compare one expectation after each rising edge
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                checkOutput(x);
            end
        end
    end

    initial begin
        $display("[TB] start");
        repeat (2) applyStimulus(1, 0, 1, 0, 0);
        repeat (3) applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 0, 1, 1, 3'd5);
        repeat (4) applyStimulus(0, 0, 1, 0, 3'd3);

        repeat (40) applyStimulus(0, 1, 1, 1, 3'd2);
        applyStimulus(0, 0, 1, 0, 0);
        repeat (14) applyStimulus(0, 1, 1, 0, 0);
        repeat (10) applyStimulus(0, 1, 0, 1, 3'd2);
        repeat (3) applyStimulus(0, 1, 1, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        repeat (5) applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 0, 1, 1, 3'd1);
        repeat (2) applyStimulus(0, 0, 1, 0, 0);

        repeat (26) applyStimulus(0, 1, 1, 0, 0);
        applyStimulus(1, 1, 1, 0, 0);
        repeat (3) applyStimulus(0, 0, 1, 0, 0);

        begin
            bit cur_mode = 1'b0;
            for (int i = 0; i < 1500; i++) begin
                bit r;
                bit en;
                bit v;
                logic [N-1:0] s;
                r  = ($urandom_range(0, 199) == 0);
                if ($urandom_range(0, 29) == 0) cur_mode = ~cur_mode;
                en = ($urandom_range(0, 9) != 0);
                v  = ($urandom_range(0, 1) == 1);
                s  = N'($urandom_range(0, W - 1));
                applyStimulus(r, cur_mode, en, v, s);
            end
        end

        @(posedge clk);
        #2;
        n_cmp = n_cmp + 1;
        if (sb.size() != 0) begin
            n_bad = n_bad + 1;
            $display("[TB] FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/decoder_nbit_scan.md
DECODER_NBIT_SCAN -- requirements
Module: decoder_nbit_scan

Interface
REQ-001 SHALL have parameter N, default 3: select width; output width is 2**N.
REQ-002 SHALL have parameter HOLD, default 4: cycles each scan index is held, legal range 1..255.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port e, input, 1: output enable; when low, y is forced to zero.
REQ-006 SHALL have port mode, input, 1: 0 selects DIRECT, 1 selects SCAN.
REQ-007 SHALL have port sel_valid, input, 1: sel is valid.
REQ-008 SHALL have port sel_ready, output, 1: block accepts sel.
REQ-009 SHALL have port sel, input, N: binary index.
REQ-010 SHALL have port y, output, 2**N: registered one-hot output.
REQ-011 SHALL have port wrap, output, 1: one-cycle pulse on scan wrap-around.

Function
REQ-012 SHALL implement state machine DIRECT/SCAN; state follows the registered mode with one cycle of latency.
REQ-013 DIRECT SHALL drive sel_ready=1; SCAN SHALL drive sel_ready=0.
REQ-014 DIRECT handshake SHALL accept sel when sel_valid&&sel_ready, and y SHALL equal one-hot(sel) on the next cycle (latency 1).
REQ-015 DIRECT with no accepted handshake SHALL hold the last index.
REQ-016 On entering SCAN, the index SHALL be 0 and the hold counter cleared.
REQ-017 SCAN SHALL hold each index for exactly HOLD cycles, then advance the index by 1.
REQ-018 Index 2**N-1 SHALL wrap to 0, with wrap=1 for exactly the first cycle of index 0 after wrap; wrap SHALL be 0 on initial SCAN entry.
REQ-019 On SCAN->DIRECT, y SHALL keep the current scan index until a new sel is accepted.
REQ-020 e=0 SHALL force y=0, freeze the index and hold counters, and suppress wrap; e=1 SHALL resume from the frozen point.
REQ-021 sel_valid while in SCAN SHALL be ignored, with no state change.
REQ-022 Arithmetic: the index counter SHALL be N bits with natural modulo wrap; the hold counter SHALL be 8 bits.

Reset
REQ-023 rst=1 SHALL set state=DIRECT, index=0, hold counter=0, y=0, wrap=0 on the next edge, overriding all other inputs including mid-scan.
REQ-024 After reset, y SHALL stay 0 until the first accepted sel or the first SCAN step with e=1.

Configuration
REQ-025 Macro DECODER_BLANK_EN, when defined, SHALL insert one blanking cycle (y=0) after each HOLD period before the next index is shown, so each scan step is HOLD+1 cycles.
REQ-026 With DECODER_BLANK_EN undefined, indices SHALL change back-to-back with no blank cycle; DIRECT behaviour is identical in both builds.

Structure
REQ-027 A shared package decoder_pkg SHALL hold the state enum (DIRECT, SCAN) and the HOLD counter width constant.
REQ-028 A combinational sub-module decoder_onehot (N->2**N with enable) SHALL be instantiated for the one-hot expansion; all registers stay in decoder_nbit_scan.

Verification
REQ-029 Reset then DIRECT, e=1, sel=5 valid for 1 cycle -> next cycle y=8'b0010_0000; y holds afterwards.
REQ-030 SCAN, HOLD=4, e=1 -> y walks 0x01,0x02,...,0x80, each for 4 cycles; wrap=1 for one cycle when y returns to 0x01 (cycle 32).
REQ-031 SCAN at index 3, e=0 for 10 cycles -> y=0, wrap=0; on e=1, index 3 resumes with the remaining hold count.
REQ-032 rst asserted mid-scan at index 6 -> next cycle y=0, state DIRECT, sel_ready=1.
REQ-033 SCAN with sel_valid=1, sel=2 -> sel_ready=0 and scan sequence undisturbed; switch to DIRECT at index 4 -> y=0x10 held until next accept.
REQ-034 DECODER_BLANK_EN build, HOLD=2 -> pattern 0x01,0x01,0x00,0x02,0x02,0x00,...
